// File: rtl/instruction_loader.sv
// instruction_loader: assembles UART bytes into big-endian words and writes them to instruction memory until HALT or full.
module instruction_loader #(
    parameter int                   PC_WIDTH  = 9,
    parameter int                   NB_WIDTH  = 32,
    parameter int                   NB_BYTE   = 8,
    parameter logic [NB_WIDTH-1:0]  HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    output logic                o_wr_en,
    output logic [PC_WIDTH-1:0] o_wr_addr,
    output logic [NB_WIDTH-1:0] o_wr_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_full,
    output logic [PC_WIDTH:0]   o_word_count
);
    localparam int NBYTES = NB_WIDTH / NB_BYTE;
    localparam int CW     = NBYTES > 1 ? $clog2(NBYTES) : 1;
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
    state_t              r_state;
    logic [PC_WIDTH-1:0] r_addr;
    logic [CW-1:0]       r_cnt;
    logic [NB_WIDTH-1:0] r_buf;
    logic                r_wr_en;
    logic [PC_WIDTH-1:0] r_wr_addr;
    logic [NB_WIDTH-1:0] r_wr_data;
    logic                r_busy;
    logic                r_done;
    logic                r_full;
    logic [PC_WIDTH:0]   r_word_count;
    logic [NB_WIDTH-1:0] w_shift;
    logic                w_halt;
    logic                w_last_addr;
    assign w_shift     = {r_buf[NB_WIDTH-NB_BYTE-1:0], i_rx_data};
    assign w_halt      = r_wr_data == HALT_WORD;
    assign w_last_addr = &r_addr;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_buf        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_full       <= 1'b0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: if (i_start) begin
                    r_state      <= RECV;
                    r_addr       <= '0;
                    r_cnt        <= '0;
                    r_word_count <= '0;
                    r_full       <= 1'b0;
                    r_done       <= 1'b0;
                    r_busy       <= 1'b1;
                end
                RECV: if (i_rx_valid) begin
                    r_buf <= w_shift;
                    if (r_cnt == CW'(NBYTES - 1)) begin
                        r_state   <= WRITE;
                        r_cnt     <= '0;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= w_shift;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                WRITE: begin
                    r_wr_en      <= 1'b0;
                    r_word_count <= r_word_count + (PC_WIDTH+1)'(1);
                    if (w_halt || w_last_addr) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_full  <= !w_halt;
                    end else begin
                        // a byte arriving during the write cycle starts the next word
                        r_state <= RECV;
                        r_addr  <= r_addr + PC_WIDTH'(1);
                        if (i_rx_valid) begin
                            r_buf <= w_shift;
                            r_cnt <= CW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_full       = r_full;
    assign o_word_count = r_word_count;
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: randomized and directed load scenarios against a word-list model of the loader.
module tb_instruction_loader;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_wr_en;
    logic [8:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_busy;
    logic        o_done;
    logic        o_full;
    logic [9:0]  o_word_count;
    int vectors = 0;
    int miscompares = 0;
    logic [8:0]  wa[$];
    logic [31:0] wd[$];
    int wide = 0;
    logic prev_en = 1'b0;

    instruction_loader dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_busy(o_busy), .o_done(o_done), .o_full(o_full), .o_word_count(o_word_count)
    );

    always #5 i_clk = ~i_clk;

    // write log: every write beat seen just after the edge, and any beat wider than one cycle
    always @(posedge i_clk) begin
        #1;
        if (o_wr_en) begin
            wa.push_back(o_wr_addr);
            wd.push_back(o_wr_data);
        end
        if (o_wr_en && prev_en) wide++;
        prev_en = o_wr_en;
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wide = 0;
    endtask

    task automatic drive(input logic [7:0] b, input int gap, input logic st);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        i_start    = st;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        i_start    = 1'b0;
        repeat (gap) @(negedge i_clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 3; k >= 0; k--) drive(w[k*8 +: 8], gap, 1'b0);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string name);
        int n = 0;
        while (!o_done && n < lim) begin
            @(negedge i_clk);
            n++;
        end
        vectors++;
        if (o_done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_timeout got o_done=%b exp 1 after %0d cycles", name, o_done, n);
        end
    endtask

    // compares the write log against the expected word list (addresses 0,1,2,... in order)
    task automatic check_writes(input logic [31:0] words[$], input string name);
        vectors++;
        if (wa.size() != words.size()) begin
            miscompares++;
            $display("FAIL %s write_count got %0d exp %0d", name, wa.size(), words.size());
        end
        for (int i = 0; i < words.size(); i++) begin
            logic [8:0]  ga = (i < wa.size()) ? wa[i] : 9'hx;
            logic [31:0] gd = (i < wd.size()) ? wd[i] : 32'hx;
            vectors++;
            if (ga !== 9'(i) || gd !== words[i]) begin
                miscompares++;
                $display("FAIL %s write%0d got addr %0d data %h exp addr %0d data %h", name, i, ga, gd, i, words[i]);
            end
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_full, o_word_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got en=%b addr=%h data=%h busy=%b done=%b full=%b cnt=%0d exp all 0",
                     o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_full, o_word_count);
        end
        pulse_start();
        send_word(32'h12345678, 0);
        drive(8'h9A, 0, 1'b0);
        drive(8'hBC, 0, 1'b0);
        @(posedge i_clk);
        #2 i_reset = 1'b1;
        #1;
        vectors++;
        if ({o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_full, o_word_count} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got en=%b addr=%h data=%h busy=%b done=%b full=%b cnt=%0d exp all 0",
                     o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_full, o_word_count);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic test_halt();
        logic [31:0] exp_w[$] = '{32'h12345678, 32'hFFFFFFFF};
        clear_log();
        pulse_start();
        drive(8'h12, 1, 1'b0);
        drive(8'h34, 2, 1'b0);
        drive(8'h56, 0, 1'b0);
        drive(8'h78, 0, 1'b0);
        vectors++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== 9'd0) begin
            miscompares++;
            $display("FAIL halt_latency got en=%b addr=%0d exp en=1 addr=0", o_wr_en, o_wr_addr);
        end
        @(negedge i_clk);
        vectors++;
        if (o_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_pulse_width got en=%b exp 0", o_wr_en);
        end
        send_word(32'hFFFFFFFF, 1);
        wait_done(50, "halt");
        check_writes(exp_w, "halt");
        vectors++;
        if (o_word_count !== 10'd2 || o_full !== 1'b0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_end got cnt=%0d full=%b busy=%b exp cnt=2 full=0 busy=0", o_word_count, o_full, o_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w[$] = '{32'hAABBCCDD, 32'h01020304, 32'hFFFFFFFF};
        clear_log();
        pulse_start();
        foreach (exp_w[i]) send_word(exp_w[i], 0);
        drive(8'h55, 0, 1'b0);
        wait_done(20, "b2b");
        repeat (3) @(negedge i_clk);
        check_writes(exp_w, "b2b");
        vectors++;
        if (wide !== 0 || o_word_count !== 10'd3) begin
            miscompares++;
            $display("FAIL b2b_width got wide=%0d cnt=%0d exp wide=0 cnt=3", wide, o_word_count);
        end
    endtask

    task automatic test_ignore();
        logic [31:0] exp_w[$] = '{32'hDEADBEEF, 32'hFFFFFFFF};
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        clear_log();
        send_word(32'hCAFEF00D, 0);
        send_word(32'h01234567, 1);
        repeat (3) @(negedge i_clk);
        vectors++;
        if (wa.size() !== 0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_idle got writes=%0d busy=%b exp writes=0 busy=0", wa.size(), o_busy);
        end
        pulse_start();
        drive(8'hDE, 0, 1'b0);
        drive(8'hAD, 1, 1'b0);
        pulse_start();
        drive(8'hBE, 0, 1'b1);
        drive(8'hEF, 0, 1'b0);
        send_word(32'hFFFFFFFF, 0);
        wait_done(20, "ignore");
        check_writes(exp_w, "ignore");
    endtask

    task automatic test_random();
        for (int l = 0; l < 4; l++) begin
            logic [31:0] words[$];
            int nw = $urandom_range(1, 6);
            for (int i = 0; i < nw; i++) begin
                logic [31:0] w = $urandom;
                words.push_back(w == 32'hFFFFFFFF ? 32'h0 : w);
            end
            words.push_back(32'hFFFFFFFF);
            clear_log();
            pulse_start();
            foreach (words[i])
                for (int k = 3; k >= 0; k--)
                    drive(words[i][k*8 +: 8], $urandom_range(0, 2),
                          (i < nw) && ($urandom_range(0, 7) == 0));
            wait_done(20, "random");
            check_writes(words, "random");
            vectors++;
            if (o_word_count !== 10'(nw + 1) || o_full !== 1'b0 || wide !== 0) begin
                miscompares++;
                $display("FAIL random_end got cnt=%0d full=%b wide=%0d exp cnt=%0d full=0 wide=0", o_word_count, o_full, wide, nw + 1);
            end
        end
    endtask

    task automatic test_full();
        int bad = 0;
        clear_log();
        pulse_start();
        for (int a = 0; a < 512; a++) send_word(32'(a), 0);
        wait_done(20, "full");
        vectors++;
        if (wa.size() !== 512 || (wa.size() > 0 && wa[wa.size()-1] !== 9'd511)) begin
            miscompares++;
            $display("FAIL full_writes got %0d writes last addr %0d exp 512 writes last addr 511",
                     wa.size(), wa.size() > 0 ? wa[wa.size()-1] : 9'd0);
        end
        foreach (wa[i]) if (wa[i] !== 9'(i) || wd[i] !== 32'(i)) bad++;
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL full_data got %0d wrong writes exp 0", bad);
        end
        vectors++;
        if (o_full !== 1'b1 || o_word_count !== 10'd512) begin
            miscompares++;
            $display("FAIL full_flags got full=%b cnt=%0d exp full=1 cnt=512", o_full, o_word_count);
        end
        clear_log();
        send_word(32'h11111111, 0);
        send_word(32'hFFFFFFFF, 0);
        repeat (3) @(negedge i_clk);
        vectors++;
        if (wa.size() !== 0 || o_done !== 1'b1) begin
            miscompares++;
            $display("FAIL full_after got writes=%0d done=%b exp writes=0 done=1", wa.size(), o_done);
        end
    endtask

    task automatic test_restart();
        logic [31:0] exp_w[$] = '{32'h11223344, 32'hFFFFFFFF};
        i_start = 1'b1;
        #1;
        vectors++;
        if (o_done !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_done_hold got done=%b exp 1", o_done);
        end
        @(negedge i_clk);
        i_start = 1'b0;
        vectors++;
        if (o_done !== 1'b0 || o_full !== 1'b0 || o_busy !== 1'b1 || o_word_count !== 10'd0) begin
            miscompares++;
            $display("FAIL restart_clear got done=%b full=%b busy=%b cnt=%0d exp 0 0 1 0", o_done, o_full, o_busy, o_word_count);
        end
        clear_log();
        send_word(32'hA0A1A2A3, 0);
        send_word(32'hB0B1B2B3, 1);
        drive(8'hC0, 0, 1'b0);
        drive(8'hC1, 0, 1'b0);
        i_reset = 1'b1;
        #1;
        vectors++;
        if (o_busy !== 1'b0 || o_word_count !== 10'd0) begin
            miscompares++;
            $display("FAIL restart_reset got busy=%b cnt=%0d exp busy=0 cnt=0", o_busy, o_word_count);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        drive(8'hC2, 0, 1'b0);
        drive(8'hC3, 0, 1'b0);
        repeat (3) @(negedge i_clk);
        vectors++;
        if (wa.size() !== 2) begin
            miscompares++;
            $display("FAIL restart_partial got %0d writes exp 2", wa.size());
        end
        clear_log();
        pulse_start();
        foreach (exp_w[i]) send_word(exp_w[i], 1);
        wait_done(30, "restart");
        check_writes(exp_w, "restart");
    endtask

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data = '0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        test_reset();
        test_halt();
        test_back_to_back();
        test_ignore();
        test_random();
        test_full();
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Sequences the write port of instruction_memory during program load.
- Takes a byte stream from the debug UART receiver and assembles bytes into 32-bit instruction words.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Stops at a HALT word or when memory is full, then flags completion to the debug unit, which releases the pipeline.

Parameters:
- PC_WIDTH, 9, instruction-memory address width; DEPTH = 2**PC_WIDTH words.
- NB_WIDTH, 32, instruction word width; must be a multiple of 8.
- NB_BYTE, 8, receive byte width.
- HALT_WORD, 32'hFFFFFFFF, instruction value that terminates loading.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  one-cycle pulse; begins a load at address 0.
- i_rx_data  input  NB_BYTE  received byte.
- i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid this cycle.
- o_wr_en  output  1  instruction_memory write enable.
- o_wr_addr  output  PC_WIDTH  instruction_memory write address.
- o_wr_data  output  NB_WIDTH  instruction_memory write data.
- o_busy  output  1  load in progress (RECV or WRITE).
- o_done  output  1  load finished; held until next i_start.
- o_full  output  1  load ended because address DEPTH-1 was written without a HALT word.
- o_word_count  output  PC_WIDTH+1  number of words written in the current or last load.

Behaviour:
- Reset, asynchronous:
  - state=IDLE.
  - All outputs 0: o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_full, o_word_count.
  - Internal byte counter and shift buffer are 0.
- Byte order is big-endian: the first byte received becomes bits [31:24].
- Word assembly: buffer <= {buffer[NB_WIDTH-NB_BYTE-1:0], i_rx_data}; byte counter counts 0..3.
- IDLE:
  - o_busy=0.
  - i_rx_valid is ignored.
  - On i_start: address=0, byte counter=0, o_word_count=0, o_full=0, go to RECV.
- RECV:
  - o_busy=1.
  - Each i_rx_valid shifts one byte in and increments the byte counter.
  - On the 4th byte: go to WRITE, byte counter=0.
  - i_start is ignored.
- WRITE (exactly one cycle):
  - o_wr_en=1, o_wr_addr=address, o_wr_data=assembled word.
  - o_wr_en is a Moore output, high only in WRITE.
  - Latency: 4th-byte strobe sampled at edge N → o_wr_en high from edge N to N+1.
  - o_word_count increments at the end of WRITE.
  - Next state:
    - word == HALT_WORD → DONE; the HALT word is still written.
    - else address == DEPTH-1 → DONE, o_full=1.
    - else address+1, go to RECV.
  - An i_rx_valid in the WRITE cycle is captured as byte 1 of the next word (byte counter=1). It is discarded if the next state is DONE.
- DONE:
  - o_done=1, o_busy=0.
  - o_wr_addr and o_wr_data hold the last written values.
  - i_rx_valid is ignored.
  - i_start restarts the load: clears o_done and o_full, goes to RECV as from IDLE.
- Simultaneous i_start and i_rx_valid in IDLE/DONE: the start is taken and the byte is discarded.
- Address never wraps; no writes occur beyond DEPTH-1.
- Reset mid-load aborts immediately to IDLE. Memory contents already written are not cleared by this block.
- o_wr_addr and o_wr_data are registered; they change only on entry to WRITE.

Test Plan:
- Reset: assert i_reset asynchronously mid-cycle → all outputs 0 before the next clock edge; state IDLE.
- Single-word load then HALT:
  - Stimulus: i_start, then bytes 12,34,56,78,FF,FF,FF,FF.
  - Write 1: o_wr_en pulse with addr 0, data 12345678.
  - Write 2: o_wr_en pulse with addr 1, data FFFFFFFF.
  - End: o_done=1, o_word_count=2, o_full=0.
- Back-to-back bytes:
  - Stimulus: i_rx_valid every cycle, including the WRITE cycle; bytes AA,BB,CC,DD,01,02,03,04.
  - Required: addr0=AABBCCDD, addr1=01020304; no byte lost; each o_wr_en is exactly one cycle wide.
- Full memory:
  - Stimulus: 512 non-HALT words, e.g. data = address.
  - Required: last write at addr 511; then o_done=1, o_full=1, o_word_count=512.
  - Further bytes produce no o_wr_en.
- Ignore rules:
  - Bytes before i_start produce no writes.
  - i_start after 2 bytes of a word is ignored; the word completes normally.
- Reset and restart:
  - i_reset after 2 bytes of word 3 → IDLE; no write for the partial word.
  - New i_start → next write at addr 0.
  - i_start from DONE clears o_done the cycle after the start.
